// File: rtl/instruction_memory_loadable.sv
// Runtime-loadable instruction memory: streaming load port fills a word array,
// fetch port performs a one-cycle registered read with fault/default handling.
module instruction_memory_loadable #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_INST = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_req,
    input  logic [31:0]             fetch_addr,
    output logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [DATA_WIDTH-1:0]   fetch_inst,
    output logic                    fetch_fault,
    input  logic                    load_start,
    input  logic                    load_valid,
    input  logic [DATA_WIDTH-1:0]   load_data,
    input  logic                    load_last,
    output logic                    load_ready,
    output logic                    load_done,
    output logic [$clog2(DEPTH):0]  load_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   load_done_q, load_done_d;
    logic                   fetch_ready_q, fetch_ready_d;
    logic                   load_ready_q, load_ready_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic [DATA_WIDTH-1:0]  fetch_inst_q, fetch_inst_d;
    logic                   fetch_fault_q, fetch_fault_d;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   wr_en_c;
    logic [29:0]            idx_c;
    logic                   fault_c;
    logic                   unloaded_c;
    logic                   accept_c;

    // Load sequencing; ready flags are registered copies of the next state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        load_done_d = 1'b0;
        wr_en_c     = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    ptr_d   = '0;
                    count_d = '0;
                end else if (load_valid) begin
                    wr_en_c = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                    if (count_q != CW'(DEPTH)) begin
                        count_d = count_q + CW'(1);
                    end
                    if (load_last || (ptr_q == AW'(DEPTH - 1))) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        fetch_ready_d = (state_d == RUN);
        load_ready_d  = (state_d == LOAD);
    end

    // Fetch decode: faults take priority over the unloaded-region default.
    always_comb begin
        idx_c         = fetch_addr[31:2];
        fault_c       = (fetch_addr[1:0] != 2'b00) || (32'(idx_c) >= 32'(DEPTH));
        unloaded_c    = (32'(idx_c) >= 32'(count_q));
        accept_c      = fetch_req & fetch_ready_q;
        fetch_valid_d = accept_c;
        fetch_inst_d  = fetch_inst_q;
        fetch_fault_d = fetch_fault_q;
        if (accept_c) begin
            if (fault_c) begin
                fetch_inst_d  = DEFAULT_INST;
                fetch_fault_d = 1'b1;
            end else if (unloaded_c) begin
                fetch_inst_d  = DEFAULT_INST;
                fetch_fault_d = 1'b0;
            end else begin
                fetch_inst_d  = mem[fetch_addr[AW+1:2]];
                fetch_fault_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            count_q       <= '0;
            load_done_q   <= 1'b0;
            fetch_ready_q <= 1'b0;
            load_ready_q  <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= DEFAULT_INST;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            load_done_q   <= load_done_d;
            fetch_ready_q <= fetch_ready_d;
            load_ready_q  <= load_ready_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // Array is intentionally unreset; load_count masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[ptr_q] <= load_data;
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign load_ready  = load_ready_q;
    assign load_done   = load_done_q;
    assign load_count  = count_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_inst  = fetch_inst_q;
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Randomized scenario bench for instruction_memory_loadable against an array model.
module tb_instruction_memory_loadable;

    localparam logic [31:0] DEF = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        fetch_fault;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [8:0]  load_count;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] model_mem [256];
    int          model_count = 0;

    instruction_memory_loadable dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_fault(fetch_fault),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (load_done) done_cnt++;

    function automatic logic exp_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        if (exp_fault(a)) return DEF;
        if ((a >> 2) >= 32'(model_count)) return DEF;
        return model_mem[a[9:2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_count = 0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        model_mem[model_count] = d;
        model_count++;
    endtask

    task automatic fetch_one(input logic [31:0] a, output logic v, output logic [31:0] i,
                             output logic f);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req = 1'b0;
        v = fetch_valid;
        i = fetch_inst;
        f = fetch_fault;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        tick(); tick();
        total_cnt++; if (fetch_ready !== 1'b0) $display("FAIL reset_fetch_ready: got %b want 0", fetch_ready); else pass_cnt++;
        total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); else pass_cnt++;
        total_cnt++; if (fetch_inst !== DEF) $display("FAIL reset_fetch_inst: got %h want %h", fetch_inst, DEF); else pass_cnt++;
        total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL reset_fetch_fault: got %b want 0", fetch_fault); else pass_cnt++;
        total_cnt++; if (load_ready !== 1'b0) $display("FAIL reset_load_ready: got %b want 0", load_ready); else pass_cnt++;
        total_cnt++; if (load_done !== 1'b0) $display("FAIL reset_load_done: got %b want 0", load_done); else pass_cnt++;
        total_cnt++; if (load_count !== 9'd0) $display("FAIL reset_load_count: got %0d want 0", load_count); else pass_cnt++;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (fetch_valid !== 1'b0 || fetch_ready !== 1'b0) seen++;
        end
        fetch_req = 1'b0;
        total_cnt++; if (seen != 0) $display("FAIL idle_fetch_ignored: got %0d active cycles want 0", seen); else pass_cnt++;
    endtask

    task automatic test_load25();
        int d0;
        logic [31:0] d;
        d0 = done_cnt;
        start_load();
        total_cnt++; if (load_ready !== 1'b1) $display("FAIL load25_ready: got %b want 1", load_ready); else pass_cnt++;
        for (int k = 0; k < 25; k++) begin
            d = (k == 0) ? 32'h8c08_0000 : (k == 24) ? 32'h0810_0018 : $urandom;
            load_word(d, k == 24);
        end
        total_cnt++; if (load_done !== 1'b1) $display("FAIL load25_done_pulse: got %b want 1", load_done); else pass_cnt++;
        tick();
        total_cnt++; if (done_cnt - d0 != 1) $display("FAIL load25_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (load_count !== 9'd25) $display("FAIL load25_count: got %0d want 25", load_count); else pass_cnt++;
        total_cnt++; if (fetch_ready !== 1'b1) $display("FAIL load25_fetch_ready: got %b want 1", fetch_ready); else pass_cnt++;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        fetch_addr = 32'h60;
        total_cnt++;
        if (fetch_valid !== 1'b1 || fetch_inst !== 32'h8c08_0000 || fetch_fault !== 1'b0)
            $display("FAIL b2b_first: got v=%b i=%h f=%b want v=1 i=8c080000 f=0", fetch_valid, fetch_inst, fetch_fault);
        else pass_cnt++;
        tick();
        fetch_req = 1'b0;
        total_cnt++;
        if (fetch_valid !== 1'b1 || fetch_inst !== 32'h0810_0018 || fetch_fault !== 1'b0)
            $display("FAIL b2b_second: got v=%b i=%h f=%b want v=1 i=08100018 f=0", fetch_valid, fetch_inst, fetch_fault);
        else pass_cnt++;
    endtask

    task automatic test_fetch_edges();
        logic [31:0] addrs [3];
        logic v, f;
        logic [31:0] i;
        addrs[0] = 32'h64; addrs[1] = 32'h400; addrs[2] = 32'h2;
        for (int k = 0; k < 3; k++) begin
            fetch_one(addrs[k], v, i, f);
            total_cnt++;
            if (v !== 1'b1 || i !== exp_inst(addrs[k]) || f !== exp_fault(addrs[k]))
                $display("FAIL edge_fetch_%h: got v=%b i=%h f=%b want v=1 i=%h f=%b",
                         addrs[k], v, i, f, exp_inst(addrs[k]), exp_fault(addrs[k]));
            else pass_cnt++;
        end
        fetch_one(32'h0, v, i, f);
        tick();
        total_cnt++;
        if (fetch_valid !== 1'b0 || fetch_inst !== 32'h8c08_0000 || fetch_fault !== 1'b0)
            $display("FAIL hold_after_fetch: got v=%b i=%h f=%b want v=0 i=8c080000 f=0", fetch_valid, fetch_inst, fetch_fault);
        else pass_cnt++;
        load_valid = 1'b1; load_data = $urandom;
        tick();
        load_valid = 1'b0;
        total_cnt++;
        if (load_count !== 9'd25 || load_ready !== 1'b0)
            $display("FAIL run_load_ignored: got count=%0d ready=%b want 25 0", load_count, load_ready);
        else pass_cnt++;
    endtask

    task automatic test_random_fetch();
        logic        req;
        logic [31:0] a;
        logic [31:0] want_i;
        logic        want_f;
        want_i = fetch_inst;
        want_f = fetch_fault;
        for (int k = 0; k < 60; k++) begin
            req = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, 300)) << 2;
                2:       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                default: a = $urandom;
            endcase
            fetch_req = req; fetch_addr = a;
            if (req) begin
                want_i = exp_inst(a);
                want_f = exp_fault(a);
            end
            tick();
            total_cnt++;
            if (fetch_valid !== req || fetch_inst !== want_i || fetch_fault !== want_f)
                $display("FAIL rand_fetch_%0d addr=%h: got v=%b i=%h f=%b want v=%b i=%h f=%b",
                         k, a, fetch_valid, fetch_inst, fetch_fault, req, want_i, want_f);
            else pass_cnt++;
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_full_load();
        logic v, f;
        logic [31:0] i;
        int d0;
        d0 = done_cnt;
        start_load();
        for (int k = 0; k < 256; k++) load_word($urandom, 1'b0);
        total_cnt++; if (load_done !== 1'b1) $display("FAIL full_done_pulse: got %b want 1", load_done); else pass_cnt++;
        total_cnt++; if (load_count !== 9'd256) $display("FAIL full_count: got %0d want 256", load_count); else pass_cnt++;
        fetch_one(32'h3FC, v, i, f);
        total_cnt++;
        if (v !== 1'b1 || i !== model_mem[255] || f !== 1'b0)
            $display("FAIL full_last_word: got v=%b i=%h f=%b want v=1 i=%h f=0", v, i, f, model_mem[255]);
        else pass_cnt++;
        total_cnt++; if (done_cnt - d0 != 1) $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_restart();
        logic v, f;
        logic [31:0] i;
        logic [31:0] want;
        want = exp_inst(32'h3FC);
        fetch_req = 1'b1; fetch_addr = 32'h3FC; load_start = 1'b1;
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        model_count = 0;
        total_cnt++;
        if (fetch_valid !== 1'b1 || fetch_inst !== want || load_ready !== 1'b1 || fetch_ready !== 1'b0)
            $display("FAIL start_with_fetch: got v=%b i=%h lr=%b fr=%b want v=1 i=%h lr=1 fr=0",
                     fetch_valid, fetch_inst, load_ready, fetch_ready, want);
        else pass_cnt++;
        for (int k = 0; k < 10; k++) load_word($urandom, 1'b0);
        total_cnt++; if (load_count !== 9'd10) $display("FAIL restart_pre_count: got %0d want 10", load_count); else pass_cnt++;
        load_start = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        model_count = 0;
        total_cnt++;
        if (load_count !== 9'd0 || load_ready !== 1'b1)
            $display("FAIL restart_clear: got count=%0d ready=%b want 0 1", load_count, load_ready);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) load_word($urandom, k == 2);
        fetch_one(32'h0, v, i, f);
        total_cnt++;
        if (v !== 1'b1 || i !== model_mem[0] || f !== 1'b0)
            $display("FAIL restart_word0: got v=%b i=%h f=%b want v=1 i=%h f=0", v, i, f, model_mem[0]);
        else pass_cnt++;
        total_cnt++; if (load_count !== 9'd3) $display("FAIL restart_count: got %0d want 3", load_count); else pass_cnt++;
        fetch_one(32'hC, v, i, f);
        total_cnt++;
        if (v !== 1'b1 || i !== DEF || f !== 1'b0)
            $display("FAIL restart_stale_hidden: got v=%b i=%h f=%b want v=1 i=%h f=0", v, i, f, DEF);
        else pass_cnt++;
    endtask

    task automatic test_reset_midload();
        logic v, f;
        logic [31:0] i;
        int d0;
        fetch_one(32'h4, v, i, f);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b0 || fetch_inst !== DEF)
            $display("FAIL reset_cancels_fetch: got v=%b i=%h want v=0 i=%h", fetch_valid, fetch_inst, DEF);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        start_load();
        for (int k = 0; k < 10; k++) load_word($urandom, 1'b0);
        d0 = done_cnt;
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if (load_count !== 9'd0 || load_ready !== 1'b0 || fetch_ready !== 1'b0)
            $display("FAIL midload_reset: got count=%0d lr=%b fr=%b want 0 0 0", load_count, load_ready, fetch_ready);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        model_count = 0;
        for (int k = 0; k < 5; k++) tick();
        total_cnt++; if (done_cnt != d0) $display("FAIL midload_no_done: got %0d pulses want 0", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (load_ready !== 1'b0) $display("FAIL midload_idle: got ready=%b want 0", load_ready); else pass_cnt++;
        test_load25();
    endtask

    initial begin
        test_reset();
        test_load25();
        test_fetch_edges();
        test_random_fetch();
        test_full_load();
        test_random_fetch();
        test_restart();
        test_reset_midload();
        test_random_fetch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
